bubble_pool_move: RTL and testbench

Multi-slot bubble physics engine that owns up to NUM_SLOTS bouncing bubbles and replaces the single-bubble mover. It accepts spawn requests and hit events, advances each bubble's fixed-point position once per frame, and splits a hit bubble into two smaller children. It sits between the game controller (spawn/hit) and the bubble drawing and collision logic (positions, sizes, active mask).

---
 rtl/bubble_pkg.sv | 21 ++
 rtl/bubble_slot.sv | 141 ++++++++++++++
 rtl/bubble_pool_move.sv | 190 +++++++++++++++++++
 tb/tb_bubble_pool_move.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bubble_pkg.sv
// Shared types and constants for the multi-slot bubble physics engine.
package bubble_pkg;

    typedef enum logic {
        FREE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_t;

    typedef logic [2:0] bubble_size_t;

    localparam bubble_size_t       MAX_SIZE = 3'd4;
    localparam int                 PIX_W    = 11;
    localparam int                 INT_W    = 12;
    localparam logic [PIX_W-1:0]   PIX_NONE = 11'h7FF;

    // Diameter in pixels of a bubble of the given size class.
    function automatic logic [PIX_W-1:0] diam_of(input bubble_size_t size, input int min_diam);
        return PIX_W'(min_diam) << size;
    endfunction

endpackage

// File: rtl/bubble_slot.sv
// One bubble slot: occupancy, fixed-point position/speed and wall/floor/ceiling response.
// Ceiling behaviour selected by BUBBLE_CEILING_POP_EN (defined: pop, undefined: reflect).
module bubble_slot
    import bubble_pkg::*;
#(
    parameter  int FRAC_BITS   = 6,
    parameter  int GRAVITY     = 1,
    parameter  int BASE_BOUNCE = 40,
    parameter  int BOUNCE_STEP = 12,
    parameter  int MIN_DIAM    = 8,
    parameter  int SCREEN_W    = 640,
    parameter  int SCREEN_H    = 480,
    localparam int FP_W        = INT_W + FRAC_BITS
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   load,
    input  logic                   kill,
    input  logic                   frame,
    input  logic signed [FP_W-1:0] load_x,
    input  logic signed [FP_W-1:0] load_y,
    input  logic signed [FP_W-1:0] load_vx,
    input  logic signed [FP_W-1:0] load_vy,
    input  bubble_size_t           load_size,
    output logic                   active,
    output logic                   next_active,
    output logic                   ceil_pop,
    output logic signed [FP_W-1:0] pos_x,
    output logic signed [FP_W-1:0] pos_y,
    output logic [PIX_W-1:0]       pix_x,
    output logic [PIX_W-1:0]       pix_y,
    output bubble_size_t           size
);

    localparam logic signed [FP_W-1:0] FP_ZERO  = FP_W'(0);
    localparam logic signed [FP_W-1:0] GRAV_FP  = FP_W'(GRAVITY);
    localparam logic signed [FP_W-1:0] SCR_W_FP = FP_W'(SCREEN_W) <<< FRAC_BITS;
    localparam logic signed [FP_W-1:0] SCR_H_FP = FP_W'(SCREEN_H) <<< FRAC_BITS;

    slot_state_t            state_r, state_s;
    bubble_size_t           size_r, size_s;
    logic signed [FP_W-1:0] x_r, y_r, vx_r, vy_r;
    logic signed [FP_W-1:0] x_s, y_s, vx_s, vy_s;
    logic signed [FP_W-1:0] mx_s, my_s, diam_fp_s, right_s, floor_s, bounce_s;
    logic [PIX_W-1:0]       pix_x_r, pix_y_r;
    logic                   pop_s;

    // Next-state: load beats kill beats the per-frame motion update.
    always_comb begin
        state_s   = state_r;
        size_s    = size_r;
        x_s       = x_r;
        y_s       = y_r;
        vx_s      = vx_r;
        vy_s      = vy_r;
        pop_s     = 1'b0;
        mx_s      = x_r + vx_r;
        my_s      = y_r + vy_r;
        diam_fp_s = FP_W'(diam_of(size_r, MIN_DIAM)) << FRAC_BITS;
        right_s   = SCR_W_FP - diam_fp_s;
        floor_s   = SCR_H_FP - diam_fp_s;
        bounce_s  = FP_W'(BASE_BOUNCE) + FP_W'(BOUNCE_STEP) * FP_W'(size_r);
        if (load) begin
            state_s = ACTIVE;
            size_s  = load_size;
            x_s     = load_x;
            y_s     = load_y;
            vx_s    = load_vx;
            vy_s    = load_vy;
        end else if (kill) begin
            state_s = FREE;
            size_s  = 3'd0;
        end else if (frame && (state_r == ACTIVE)) begin
            x_s = mx_s;
            y_s = my_s;
            if ((mx_s <= FP_ZERO) && (vx_r < FP_ZERO)) begin
                vx_s = -vx_r;
            end else if ((mx_s >= right_s) && (vx_r > FP_ZERO)) begin
                vx_s = -vx_r;
            end else begin
                vx_s = vx_r;
            end
            // Floor gives a fixed size-dependent rebound instead of a reflection.
            if ((my_s >= floor_s) && (vy_r > FP_ZERO)) begin
                vy_s = -bounce_s;
`ifdef BUBBLE_CEILING_POP_EN
            end else begin
                vy_s = vy_r + GRAV_FP;
            end
            if (my_s <= FP_ZERO) begin
                state_s = FREE;
                size_s  = 3'd0;
                pop_s   = 1'b1;
            end else begin
                state_s = ACTIVE;
            end
`else
            end else if ((my_s <= FP_ZERO) && (vy_r < FP_ZERO)) begin
                vy_s = -vy_r;
            end else begin
                vy_s = vy_r + GRAV_FP;
            end
`endif
        end else begin
            state_s = state_r;
        end
    end

    // Slot state and registered pixel view.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r <= FREE;
            size_r  <= 3'd0;
            x_r     <= FP_ZERO;
            y_r     <= FP_ZERO;
            vx_r    <= FP_ZERO;
            vy_r    <= FP_ZERO;
            pix_x_r <= PIX_NONE;
            pix_y_r <= PIX_NONE;
        end else begin
            state_r <= state_s;
            size_r  <= size_s;
            x_r     <= x_s;
            y_r     <= y_s;
            vx_r    <= vx_s;
            vy_r    <= vy_s;
            pix_x_r <= (state_s == ACTIVE) ? x_s[FRAC_BITS +: PIX_W] : PIX_NONE;
            pix_y_r <= (state_s == ACTIVE) ? y_s[FRAC_BITS +: PIX_W] : PIX_NONE;
        end
    end

    assign active      = (state_r == ACTIVE);
    assign next_active = (state_s == ACTIVE);
    assign ceil_pop    = pop_s;
    assign pos_x       = x_r;
    assign pos_y       = y_r;
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign size        = size_r;

endmodule

// File: rtl/bubble_pool_move.sv
// Pool of bouncing bubbles: spawn/hit handling, free-slot allocation, split and pop pulses.
// Optional BUBBLE_CEILING_POP_EN makes the ceiling destroy bubbles instead of reflecting them.
module bubble_pool_move
    import bubble_pkg::*;
#(
    parameter  int NUM_SLOTS   = 8,
    parameter  int FRAC_BITS   = 6,
    parameter  int X_SPEED     = 30,
    parameter  int GRAVITY     = 1,
    parameter  int BASE_BOUNCE = 40,
    parameter  int BOUNCE_STEP = 12,
    parameter  int SPLIT_KICK  = 24,
    parameter  int MIN_DIAM    = 8,
    parameter  int SCREEN_W    = 640,
    parameter  int SCREEN_H    = 480,
    localparam int IDX_W       = $clog2(NUM_SLOTS),
    localparam int FP_W        = INT_W + FRAC_BITS
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              startOfFrame,
    input  logic                              spawn_valid,
    output logic                              spawn_ready,
    input  logic [PIX_W-1:0]                  spawn_x,
    input  logic [PIX_W-1:0]                  spawn_y,
    input  logic [2:0]                        spawn_size,
    input  logic                              spawn_dir,
    input  logic                              hit_valid,
    input  logic [IDX_W-1:0]                  hit_slot,
    output logic [NUM_SLOTS-1:0]              active,
    output logic [NUM_SLOTS-1:0][PIX_W-1:0]   topLeftX,
    output logic [NUM_SLOTS-1:0][PIX_W-1:0]   topLeftY,
    output logic [NUM_SLOTS-1:0][2:0]         size_out,
    output logic                              split,
    output logic                              pop,
    output logic                              all_clear
);

    localparam logic signed [FP_W-1:0] FP_ZERO = FP_W'(0);
    localparam logic signed [FP_W-1:0] VX_POS  = FP_W'(X_SPEED);
    localparam logic signed [FP_W-1:0] VX_NEG  = -VX_POS;
    localparam logic signed [FP_W-1:0] VY_KICK = -(FP_W'(SPLIT_KICK));

    logic [NUM_SLOTS-1:0]   active_s, next_active_s, ceil_pop_s, load_s, kill_s, frame_s;
    logic signed [FP_W-1:0] pos_x_s [NUM_SLOTS];
    logic signed [FP_W-1:0] pos_y_s [NUM_SLOTS];
    logic signed [FP_W-1:0] ld_x_s  [NUM_SLOTS];
    logic signed [FP_W-1:0] ld_y_s  [NUM_SLOTS];
    logic signed [FP_W-1:0] ld_vx_s [NUM_SLOTS];
    logic signed [FP_W-1:0] ld_vy_s [NUM_SLOTS];
    bubble_size_t           size_s    [NUM_SLOTS];
    bubble_size_t           ld_size_s [NUM_SLOTS];
    logic [PIX_W-1:0]       pix_x_s [NUM_SLOTS];
    logic [PIX_W-1:0]       pix_y_s [NUM_SLOTS];

    logic                   free_found_s, hit_ok_s, split_s, pop_hit_s, spawn_fire_s;
    logic [IDX_W-1:0]       free_idx_s;
    bubble_size_t           hit_size_s, spawn_size_s;
    logic signed [FP_W-1:0] hit_x_s, hit_y_s, spawn_x_fp_s, spawn_y_fp_s;
    logic                   split_r, pop_r, all_clear_r;

    // Lowest-index free slot.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = IDX_W'(0);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!active_s[i] && !free_found_s) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Hit decode; hits on free or out-of-range slots are ignored.
    always_comb begin
        hit_ok_s   = 1'b0;
        hit_size_s = 3'd0;
        hit_x_s    = FP_ZERO;
        hit_y_s    = FP_ZERO;
        if (hit_valid && (int'(hit_slot) < NUM_SLOTS) && active_s[hit_slot]) begin
            hit_ok_s   = 1'b1;
            hit_size_s = size_s[hit_slot];
            hit_x_s    = pos_x_s[hit_slot];
            hit_y_s    = pos_y_s[hit_slot];
        end else begin
            hit_ok_s   = 1'b0;
        end
    end

    assign split_s      = hit_ok_s && (hit_size_s != 3'd0);
    assign pop_hit_s    = hit_ok_s && (hit_size_s == 3'd0);
    assign spawn_ready  = resetN && free_found_s && !hit_valid;
    assign spawn_fire_s = spawn_valid && spawn_ready;
    assign spawn_size_s = (spawn_size > MAX_SIZE) ? MAX_SIZE : spawn_size;
    assign spawn_x_fp_s = FP_W'({spawn_x, {FRAC_BITS{1'b0}}});
    assign spawn_y_fp_s = FP_W'({spawn_y, {FRAC_BITS{1'b0}}});

    // Per-slot load/kill/frame steering; the hit slot never moves in the frame it is hit.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            load_s[i]    = 1'b0;
            kill_s[i]    = 1'b0;
            frame_s[i]   = startOfFrame;
            ld_x_s[i]    = spawn_x_fp_s;
            ld_y_s[i]    = spawn_y_fp_s;
            ld_vx_s[i]   = spawn_dir ? VX_POS : VX_NEG;
            ld_vy_s[i]   = FP_ZERO;
            ld_size_s[i] = spawn_size_s;
            if (hit_ok_s && (int'(hit_slot) == i)) begin
                frame_s[i] = 1'b0;
                if (split_s) begin
                    load_s[i]    = 1'b1;
                    ld_x_s[i]    = hit_x_s;
                    ld_y_s[i]    = hit_y_s;
                    ld_vx_s[i]   = VX_NEG;
                    ld_vy_s[i]   = VY_KICK;
                    ld_size_s[i] = hit_size_s - 3'd1;
                end else begin
                    kill_s[i]    = 1'b1;
                end
            end else if (split_s && free_found_s && (int'(free_idx_s) == i)) begin
                load_s[i]    = 1'b1;
                ld_x_s[i]    = hit_x_s;
                ld_y_s[i]    = hit_y_s;
                ld_vx_s[i]   = VX_POS;
                ld_vy_s[i]   = VY_KICK;
                ld_size_s[i] = hit_size_s - 3'd1;
            end else if (spawn_fire_s && (int'(free_idx_s) == i)) begin
                load_s[i] = 1'b1;
            end else begin
                load_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bubble_slot #(
            .FRAC_BITS   (FRAC_BITS),
            .GRAVITY     (GRAVITY),
            .BASE_BOUNCE (BASE_BOUNCE),
            .BOUNCE_STEP (BOUNCE_STEP),
            .MIN_DIAM    (MIN_DIAM),
            .SCREEN_W    (SCREEN_W),
            .SCREEN_H    (SCREEN_H)
        ) u_slot (
            .clk         (clk),
            .resetN      (resetN),
            .load        (load_s[g]),
            .kill        (kill_s[g]),
            .frame       (frame_s[g]),
            .load_x      (ld_x_s[g]),
            .load_y      (ld_y_s[g]),
            .load_vx     (ld_vx_s[g]),
            .load_vy     (ld_vy_s[g]),
            .load_size   (ld_size_s[g]),
            .active      (active_s[g]),
            .next_active (next_active_s[g]),
            .ceil_pop    (ceil_pop_s[g]),
            .pos_x       (pos_x_s[g]),
            .pos_y       (pos_y_s[g]),
            .pix_x       (pix_x_s[g]),
            .pix_y       (pix_y_s[g]),
            .size        (size_s[g])
        );
        assign topLeftX[g] = pix_x_s[g];
        assign topLeftY[g] = pix_y_s[g];
        assign size_out[g] = size_s[g];
    end

    // Event pulses, aligned with the slot updates they describe.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            split_r     <= 1'b0;
            pop_r       <= 1'b0;
            all_clear_r <= 1'b0;
        end else begin
            split_r     <= split_s;
            pop_r       <= pop_hit_s || (|ceil_pop_s);
            all_clear_r <= (|active_s) && !(|next_active_s);
        end
    end

    assign active    = active_s;
    assign split     = split_r;
    assign pop       = pop_r;
    assign all_clear = all_clear_r;

endmodule

// File: tb/tb_bubble_pool_move.sv
// Directed self-checking bench for bubble_pool_move (honours BUBBLE_CEILING_POP_EN if defined).
module tb_bubble_pool_move;

    logic              clk = 1'b0;
    logic              resetN, startOfFrame, spawn_valid, spawn_ready, spawn_dir, hit_valid;
    logic [10:0]       spawn_x, spawn_y;
    logic [2:0]        spawn_size, hit_slot;
    logic [7:0]        active;
    logic [7:0][10:0]  topLeftX, topLeftY;
    logic [7:0][2:0]   size_out;
    logic              split, pop, all_clear;
    int                n_cmp = 0;
    int                n_bad = 0;

    bubble_pool_move dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_size(spawn_size), .spawn_dir(spawn_dir),
        .hit_valid(hit_valid), .hit_slot(hit_slot),
        .active(active), .topLeftX(topLeftX), .topLeftY(topLeftY), .size_out(size_out),
        .split(split), .pop(pop), .all_clear(all_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic spawn(input logic [10:0] x, input logic [10:0] y, input logic [2:0] s, input logic d);
        spawn_x = x; spawn_y = y; spawn_size = s; spawn_dir = d;
        spawn_valid = 1'b1;
        tick();
        spawn_valid = 1'b0;
    endtask

    task automatic hit(input logic [2:0] slot);
        hit_slot  = slot;
        hit_valid = 1'b1;
        tick();
        hit_valid = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; spawn_valid = 1'b0; spawn_dir = 1'b0;
        hit_valid = 1'b0; spawn_x = 11'd0; spawn_y = 11'd0; spawn_size = 3'd0; hit_slot = 3'd0;

        // reset state
        tick(); tick();
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_ready", 32'(spawn_ready), 32'h0);
        chk("rst_pulses", 32'({split, pop, all_clear}), 32'h0);
        chk("rst_x0", 32'(topLeftX[0]), 32'h7FF);
        chk("rst_y7", 32'(topLeftY[7]), 32'h7FF);
        resetN = 1'b1;
        tick();
        chk("ready_idle", 32'(spawn_ready), 32'h1);

        // spawn (100,50) size 2 rightward
        spawn(11'd100, 11'd50, 3'd2, 1'b1);
        chk("sp_active", 32'(active), 32'h01);
        chk("sp_x0", 32'(topLeftX[0]), 32'd100);
        chk("sp_y0", 32'(topLeftY[0]), 32'd50);
        chk("sp_size0", 32'(size_out[0]), 32'd2);
        chk("sp_x1_free", 32'(topLeftX[1]), 32'h7FF);
        frames(1);
        chk("f1_x0", 32'(topLeftX[0]), 32'd100);
        frames(2);
        chk("f3_x0", 32'(topLeftX[0]), 32'd101);
        chk("f3_y0", 32'(topLeftY[0]), 32'd50);

        // split of slot 0 with a competing spawn request
        hit_slot = 3'd0; hit_valid = 1'b1; spawn_valid = 1'b1;
        #1;
        chk("hit_blocks_ready", 32'(spawn_ready), 32'h0);
        tick();
        hit_valid = 1'b0; spawn_valid = 1'b0;
        chk("split_active", 32'(active), 32'h03);
        chk("split_pulse", 32'(split), 32'h1);
        chk("split_nopop", 32'(pop), 32'h0);
        chk("split_size0", 32'(size_out[0]), 32'd1);
        chk("split_size1", 32'(size_out[1]), 32'd1);
        chk("split_x1", 32'(topLeftX[1]), 32'd101);
        chk("split_y1", 32'(topLeftY[1]), 32'd50);
        tick();
        chk("split_once", 32'(split), 32'h0);
        frames(1);
        chk("kid_x0", 32'(topLeftX[0]), 32'd100);
        chk("kid_x1", 32'(topLeftX[1]), 32'd101);
        chk("kid_y0", 32'(topLeftY[0]), 32'd49);

        // hit slot 1 in the same cycle as a frame
        hit_slot = 3'd1; hit_valid = 1'b1; startOfFrame = 1'b1;
        tick();
        hit_valid = 1'b0; startOfFrame = 1'b0;
        chk("hf_active", 32'(active), 32'h07);
        chk("hf_split", 32'(split), 32'h1);
        chk("hf_size2", 32'(size_out[2]), 32'd0);
        chk("hf_x2", 32'(topLeftX[2]), 32'd101);
        chk("hf_y1", 32'(topLeftY[1]), 32'd49);
        tick();

        // pops of size-0 slots
        hit(3'd1);
        chk("pop1_active", 32'(active), 32'h05);
        chk("pop1_pulse", 32'({split, pop, all_clear}), 32'b010);
        chk("pop1_x1", 32'(topLeftX[1]), 32'h7FF);
        hit(3'd2);
        chk("pop2_active", 32'(active), 32'h01);
        hit(3'd5);
        chk("free_hit_ignored", 32'({active, split, pop}), 32'({8'h01, 2'b00}));
        frames(1);
        chk("moved_y0", 32'(topLeftY[0]), 32'd48);
        chk("moved_x0", 32'(topLeftX[0]), 32'd100);

        // reset with a pending hit
        resetN = 1'b0; hit_slot = 3'd0; hit_valid = 1'b1;
        tick();
        hit_valid = 1'b0;
        chk("midrst_active", 32'(active), 32'h0);
        chk("midrst_pulses", 32'({split, pop, all_clear}), 32'h0);
        chk("midrst_x0", 32'(topLeftX[0]), 32'h7FF);
        resetN = 1'b1;
        tick();

        // last bubble popped
        spawn(11'd200, 11'd100, 3'd0, 1'b0);
        chk("ac_active", 32'(active), 32'h01);
        hit(3'd0);
        chk("ac_pulses", 32'({active, pop, all_clear}), 32'({8'h00, 2'b11}));
        tick();
        chk("ac_once", 32'({pop, all_clear}), 32'h0);

        // left wall and floor rebound
        spawn(11'd0, 11'd471, 3'd0, 1'b0);
        frames(12);
        chk("floor_y12", 32'(topLeftY[0]), 32'd472);
        chk("wall_x12", 32'(topLeftX[0]), 32'd4);
        frames(1);
        chk("floor_y13", 32'(topLeftY[0]), 32'd471);
        frames(15);
        chk("floor_y28", 32'(topLeftY[0]), 32'd463);
        chk("wall_x28", 32'(topLeftX[0]), 32'd12);

        // ceiling
        do_reset();
        spawn(11'd300, 11'd0, 3'd1, 1'b1);
        hit(3'd0);
        frames(1);
`ifdef BUBBLE_CEILING_POP_EN
        chk("ceil_pop_active", 32'(active), 32'h0);
        chk("ceil_pop_pulse", 32'(pop), 32'h1);
        chk("ceil_pop_clear", 32'(all_clear), 32'h1);
`else
        chk("ceil_active", 32'(active), 32'h03);
        chk("ceil_y1", 32'(topLeftY[1]), 32'h7FF);
        frames(4);
        chk("ceil_refl_y1", 32'(topLeftY[1]), 32'd1);
        chk("ceil_refl_y0", 32'(topLeftY[0]), 32'd1);
`endif

        // full pool: split keeps only the left child
        do_reset();
        spawn_x = 11'd10; spawn_y = 11'd10; spawn_size = 3'd1; spawn_dir = 1'b1;
        spawn_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        spawn_valid = 1'b0;
        chk("full_active", 32'(active), 32'hFF);
        chk("full_ready", 32'(spawn_ready), 32'h0);
        hit(3'd3);
        chk("full_split", 32'(split), 32'h1);
        chk("full_active2", 32'(active), 32'hFF);
        chk("full_size3", 32'(size_out[3]), 32'd0);
        chk("full_size4", 32'(size_out[4]), 32'd1);
        chk("full_ready2", 32'(spawn_ready), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
